// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one unified memory port between the instruction-fetch port (IF) and
// the data port (DM: load/store/push/pop). Exactly one memory transaction is in
// flight at a time. Each transaction is followed by a one-cycle completion
// (valid) pulse on the port that owned it. A timeout counter guarantees
// completion even when mem_ack never arrives.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   if_req/if_addr           fetch request (level) and address
//   if_rdata/if_valid        fetch read data and completion pulse
//   if_stall                 if_req & ~if_valid (combinational)
//   dm_req/dm_we/dm_addr/dm_wdata   data request, write enable, address, data
//   dm_rdata/dm_valid        data read data (0 for writes) and completion pulse
//   dm_stall                 dm_req & ~dm_valid (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_ack/mem_rdata        one-cycle acknowledge with read data
//   err_timeout              sticky: a transaction timed out
//   err_spurious             sticky: mem_ack seen while mem_req was low
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state_q,        state_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic              mem_req_q,      mem_req_d;
    logic              mem_we_q,       mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
    logic              if_valid_q,     if_valid_d;
    logic              dm_valid_q,     dm_valid_d;
    logic [DATA_W-1:0] if_rdata_q,     if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,     dm_rdata_d;
    logic              err_timeout_q,  err_timeout_d;
    logic              err_spurious_q, err_spurious_d;
    // 1 = the last completed grant belonged to DM, 0 = IF.
    logic              last_dm_q,      last_dm_d;
    // Owner of the transaction being completed (valid in DONE).
    logic              done_dm_q,      done_dm_d;

    logic              grant_dm;
    logic              grant_if;
    logic [CNT_W-1:0]  cnt_inc;
    logic              busy_dm;
    logic              finish;
    logic [DATA_W-1:0] finish_rdata;

    // On contention DM wins unless DM also won last time, which alternates
    // grants and keeps either port from starving the other.
    assign grant_dm = dm_req & (~if_req | ~last_dm_q);
    assign grant_if = if_req & ~grant_dm;

    assign cnt_inc  = cnt_q + 1'b1;
    assign busy_dm  = (state_q == ST_BUSY_DM);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if_valid_d     = 1'b0;
        dm_valid_d     = 1'b0;
        if_rdata_d     = if_rdata_q;
        dm_rdata_d     = dm_rdata_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;
        last_dm_d      = last_dm_q;
        done_dm_d      = done_dm_q;
        finish         = 1'b0;
        finish_rdata   = '0;

        // An acknowledge with no request outstanding is only flagged; it has
        // no other effect on the sequencing below.
        if (mem_ack && !mem_req_q) begin
            err_spurious_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_dm) begin
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_BUSY_DM;
                end else if (grant_if) begin
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_BUSY_IF;
                end
            end

            ST_BUSY_IF, ST_BUSY_DM: begin
                if (mem_ack) begin
                    finish       = 1'b1;
                    finish_rdata = mem_we_q ? '0 : mem_rdata;
                end else if (cnt_inc == CNT_LIMIT) begin
                    // mem_req has now been high for TIMEOUT cycles; an ack in
                    // this same last cycle would have taken the branch above.
                    finish        = 1'b1;
                    finish_rdata  = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                last_dm_d = done_dm_q;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            mem_req_d = 1'b0;
            state_d   = ST_DONE;
            done_dm_d = busy_dm;
            if (busy_dm) begin
                dm_valid_d = 1'b1;
                dm_rdata_d = finish_rdata;
            end else begin
                if_valid_d = 1'b1;
                if_rdata_d = finish_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_valid_q     <= 1'b0;
            dm_valid_q     <= 1'b0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            last_dm_q      <= 1'b0;
            done_dm_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_valid_q     <= if_valid_d;
            dm_valid_q     <= dm_valid_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
            last_dm_q      <= last_dm_d;
            done_dm_q      <= done_dm_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_valid     = if_valid_q;
    assign dm_valid     = dm_valid_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

    assign if_stall     = if_req & ~if_valid_q;
    assign dm_stall     = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios with literal expectations, followed by randomized traffic
// (random requests, ack delays, spurious acks and resets). A transaction-level
// reference model predicts every output each cycle; a single compare process
// checks the DUT against it on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err_timeout;
    logic          err_spurious;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_init   = 0;  // first reset seen
    bit          m_active = 0;  // a memory access is outstanding (mem_req high)
    bit          m_done   = 0;  // this is the completion (valid) cycle
    bit          m_port   = 0;  // owner of current/last transaction: 1 = DM
    bit          m_last   = 0;  // port of the last completed transaction
    int          m_waited = 0;  // cycles mem_req has been high without ack
    bit          m_we     = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_if_rd = '0;
    logic [DW-1:0] m_dm_rd = '0;
    bit          m_to = 0;
    bit          m_sp = 0;

    task automatic model_complete(input logic [DW-1:0] v);
        m_active = 0;
        m_done   = 1;
        if (m_port) m_dm_rd = v;
        else        m_if_rd = v;
    endtask

    task automatic model_step();
        bit pick_dm;
        if (!rst_n) begin
            m_init = 1; m_active = 0; m_done = 0; m_port = 0; m_last = 0;
            m_waited = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_if_rd = '0; m_dm_rd = '0; m_to = 0; m_sp = 0;
        end else if (m_init) begin
            if (mem_ack && !m_active) m_sp = 1;
            if (m_done) begin
                m_done = 0;
                m_last = m_port;
            end else if (m_active) begin
                m_waited++;
                if (mem_ack)               model_complete(m_we ? '0 : mem_rdata);
                else if (m_waited == TO) begin
                    model_complete('0);
                    m_to = 1;
                end
            end else if (if_req || dm_req) begin
                if (if_req && dm_req) pick_dm = (m_last == 0);
                else                  pick_dm = dm_req;
                m_active = 1;
                m_waited = 0;
                m_port   = pick_dm;
                if (pick_dm) begin
                    m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                end else begin
                    m_we = 0; m_addr = if_addr; m_wdata = '0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- single compare process ----------------
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk("mem_req",   mem_req,   m_active);
            chk("mem_we",    mem_we,    m_we);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_valid",  if_valid,  m_done && !m_port);
            chk("dm_valid",  dm_valid,  m_done && m_port);
            chk("if_rdata",  if_rdata,  m_if_rd);
            chk("dm_rdata",  dm_rdata,  m_dm_rd);
            chk("if_stall",  if_stall,  if_req && !(m_done && !m_port));
            chk("dm_stall",  dm_stall,  dm_req && !(m_done && m_port));
            chk("err_timeout",  err_timeout,  m_to);
            chk("err_spurious", err_spurious, m_sp);
        end
    end

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    int order[$];
    int ack_delay = 1;

    initial begin
        rst_n = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;

        // ---- reset values ----
        repeat (2) to_pos();
        to_neg();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valids", {if_valid, dm_valid}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        chk("rst_errs", {err_timeout, err_spurious}, 0);

        // ---- contention: expect DM, IF, DM, IF ----
        to_pos();
        rst_n = 1;
        if_req = 1; if_addr = 16'h0A00;
        dm_req = 1; dm_addr = 16'h0D00; dm_we = 0;
        for (int c = 0; c < 15; c++) begin
            to_neg();
            if (if_valid) order.push_back(0);
            if (dm_valid) order.push_back(1);
            mem_ack = m_active;
            mem_rdata = 16'($urandom);
            to_pos();
            mem_ack = 0;
        end
        if_req = 0; dm_req = 0;
        chk("cont_count_ge4", order.size() >= 4, 1);
        if (order.size() >= 4) begin
            chk("cont_g0_dm", order[0], 1);
            chk("cont_g1_if", order[1], 0);
            chk("cont_g2_dm", order[2], 1);
            chk("cont_g3_if", order[3], 0);
        end
        for (int i = 0; i < 20 && (m_active || m_done); i++) begin
            mem_ack = m_active;
            to_pos();
            mem_ack = 0;
        end
        chk("cont_drained", m_active || m_done, 0);

        // ---- single fetch, ack in cycle 1 ----
        if_req = 1; if_addr = 16'h0040;
        to_neg();
        chk("f0_stall", if_stall, 1);
        chk("f0_mem_req", mem_req, 0);
        to_pos(); mem_ack = 1; mem_rdata = 16'hBEEF;
        to_neg();
        chk("f1_mem_req", mem_req, 1);
        chk("f1_mem_addr", mem_addr, 16'h0040);
        chk("f1_stall", if_stall, 1);
        to_pos(); mem_ack = 0; mem_rdata = 16'h5555;
        to_neg();
        chk("f2_if_valid", if_valid, 1);
        chk("f2_if_rdata", if_rdata, 16'hBEEF);
        chk("f2_stall", if_stall, 0);
        chk("f2_mem_req", mem_req, 0);
        if_req = 0;
        to_pos();
        to_neg();
        chk("f3_if_valid", if_valid, 0);
        chk("f3_if_rdata_hold", if_rdata, 16'hBEEF);

        // ---- timeout: no ack, mem_req high exactly TO cycles ----
        dm_req = 1; dm_we = 0; dm_addr = 16'h0100; mem_rdata = 16'hA5A5;
        for (int j = 1; j <= TO; j++) begin
            to_pos();
            to_neg();
            chk("to_mem_req_hi", mem_req, 1);
            chk("to_no_valid", dm_valid, 0);
        end
        to_pos();
        to_neg();
        chk("to_mem_req_lo", mem_req, 0);
        chk("to_dm_valid", dm_valid, 1);
        chk("to_dm_rdata", dm_rdata, 0);
        chk("to_err", err_timeout, 1);
        dm_req = 0;
        to_pos();

        // ---- good load after timeout: error stays sticky ----
        dm_req = 1; dm_addr = 16'h0200;
        to_pos(); mem_ack = 1; mem_rdata = 16'h7777;
        to_neg();
        chk("ld_mem_req", mem_req, 1);
        to_pos(); mem_ack = 0;
        to_neg();
        chk("ld_dm_valid", dm_valid, 1);
        chk("ld_dm_rdata", dm_rdata, 16'h7777);
        chk("ld_err_sticky", err_timeout, 1);
        dm_req = 0;
        to_pos();

        // ---- store, ack after 3 cycles ----
        dm_req = 1; dm_we = 1; dm_addr = 16'h1FFE; dm_wdata = 16'h1234;
        for (int j = 1; j <= 3; j++) begin
            to_pos();
            mem_ack = (j == 3);
            mem_rdata = 16'hFFFF;
            to_neg();
            chk("st_mem_req", mem_req, 1);
            chk("st_mem_we", mem_we, 1);
            chk("st_mem_addr", mem_addr, 16'h1FFE);
            chk("st_mem_wdata", mem_wdata, 16'h1234);
            chk("st_stall", dm_stall, 1);
        end
        to_pos(); mem_ack = 0;
        to_neg();
        chk("st_dm_valid", dm_valid, 1);
        chk("st_dm_rdata", dm_rdata, 0);
        chk("st_mem_req_lo", mem_req, 0);
        dm_req = 0; dm_we = 0;
        to_pos();

        // ---- spurious ack in IDLE ----
        mem_ack = 1;
        to_pos(); mem_ack = 0;
        to_neg();
        chk("sp_err", err_spurious, 1);
        chk("sp_no_valid", {if_valid, dm_valid}, 0);
        chk("sp_mem_req", mem_req, 0);
        if_req = 1; if_addr = 16'h0300;
        to_pos();
        to_neg();
        chk("sp_still_idle_grant", mem_req, 1);
        mem_ack = 1;
        to_pos(); mem_ack = 0; if_req = 0;
        to_pos();

        // ---- reset in the middle of a DM transaction ----
        dm_req = 1; dm_addr = 16'h0400;
        to_pos();
        to_pos();
        rst_n = 0; dm_req = 0;
        to_pos();
        rst_n = 1;
        to_neg();
        chk("rm_mem_req", mem_req, 0);
        chk("rm_dm_valid", dm_valid, 0);
        chk("rm_errs_clear", {err_timeout, err_spurious}, 0);
        to_pos();
        to_neg();
        chk("rm_no_late_valid", dm_valid, 0);
        mem_ack = 1;
        to_pos(); mem_ack = 0;
        to_neg();
        chk("rm_late_ack_spurious", err_spurious, 1);
        to_pos();

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            mem_rdata = 16'($urandom);
            if (m_active) begin
                if (m_waited == 0) ack_delay = $urandom_range(1, TO + 1);
                mem_ack = (m_waited + 1 == ack_delay);
            end else begin
                mem_ack = ($urandom_range(0, 29) == 0);
            end
            if (if_req && !(m_done && !m_port)) begin
                if ($urandom_range(0, 49) == 0) if_req = 0;
            end else begin
                if_req  = ($urandom_range(0, 2) == 0);
                if_addr = 16'($urandom);
            end
            if (dm_req && !(m_done && m_port)) begin
                if ($urandom_range(0, 49) == 0) dm_req = 0;
            end else begin
                dm_req   = ($urandom_range(0, 2) == 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
            to_pos();
        end
        rst_n = 1; mem_ack = 0; if_req = 0; dm_req = 0;
        repeat (3) to_pos();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between the instruction-fetch port (IF) and the data port (DM). The DM port carries load, store, push and pop; push and pop addresses come from the stack-pointer path. The block sits between the fetch/memory pipeline stages and the memory. It arbitrates requests, sequences one memory transaction at a time and produces per-port stall signals. It also watches for a lost acknowledge with a timeout, so the pipeline never hangs forever.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- TIMEOUT, 255, maximum cycles to wait for mem_ack; must be ≥ 1; counter width is clog2(TIMEOUT+1)
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetch data; meaningful only when if_valid is high
- if_valid  out  1  one-cycle completion pulse for the fetch port
- if_stall  out  1  combinational: if_req & ~if_valid
- dm_req  in  1  data request; level, held until dm_valid
- dm_we  in  1  1 = store/push, 0 = load/pop
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data; for writes it is 0
- dm_valid  out  1  one-cycle completion pulse for the data port
- dm_stall  out  1  combinational: dm_req & ~dm_valid
- mem_req  out  1  memory request; registered, held until ack or timeout
- mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  registered; stable while mem_req is high
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- err_timeout  out  1  sticky; set when a transaction times out
- err_spurious  out  1  sticky; set when mem_ack arrives while mem_req is low

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY_IF: fetch transaction in flight.
  - BUSY_DM: data transaction in flight.
  - DONE: completion cycle.
- Arbitration happens in IDLE only:
  - Only one port requesting: that port is granted.
  - Both ports requesting: DM wins, unless the previous completed grant was DM, in which case IF wins. This is round-robin on contention and removes starvation either way.
- Grant action: latch the winner's addr/we/wdata into the mem_* registers, assert mem_req, clear the timeout counter and move to BUSY_x. An IF grant forces mem_we = 0 and mem_wdata = 0.
- In BUSY_x:
  - mem_ack: capture mem_rdata (or 0 on a write), deassert mem_req, go to DONE and pulse x_valid.
  - No ack: increment the counter. When the counter reaches TIMEOUT, deassert mem_req, force rdata = 0, set err_timeout, go to DONE and pulse x_valid.
- DONE: x_valid is high for exactly this cycle, then the FSM returns to IDLE. IDLE may re-grant on the next edge.
- last_grant flag: updated in DONE to the completed port.
- A port that drops req mid-transaction does not abort it. The memory access still completes and the valid pulse is still issued; the requester discards it.
- mem_ack in IDLE or DONE sets err_spurious. mem_rdata is ignored in that case, and state is unchanged.
- Error flags clear only on reset.

## Timing
- Reset values (cycle after rst_n sampled low): state = IDLE; mem_req = mem_we = 0; mem_addr = mem_wdata = 0; if_valid = dm_valid = 0; if_rdata = dm_rdata = 0; err_* = 0; last_grant = IF; counter = 0.
- Reset mid-transaction: the cycle after reset, mem_req = 0 and no valid pulse is issued; the in-flight access is abandoned.
- Transaction latency:
  - Request seen in IDLE at edge 0.
  - mem_req high from cycle 1.
  - Ack in cycle k (k ≥ 1).
  - x_valid high in cycle k+1.
  - IDLE at cycle k+2.
- Minimum latency from request to valid is 2 cycles (ack in cycle 1). Back-to-back throughput is one transaction per 3 cycles at a zero-wait memory.
- Timeout: with no ack, mem_req is high for exactly TIMEOUT cycles, and valid follows in the next cycle.
- if_rdata/dm_rdata hold their value until the next completion on that port.
- x_stall is high every cycle that x_req is high, except the valid cycle.

## Test plan
- Single fetch, ack in cycle 1: if_req = 1 with addr 0x0040, mem_rdata = 0xBEEF → mem_req high in cycle 1 only, if_valid and if_rdata = 0xBEEF in cycle 2, if_stall = 1 in cycles 0–1.
- Contention: if_req and dm_req both held high, last_grant = IF after reset → grant order DM, IF, DM, IF. Each port gets exactly one grant per two transactions.
- Store: dm_we = 1, addr 0x1FFE, wdata 0x1234, ack after 3 cycles → mem_we = 1, mem_addr and mem_wdata stable for 3 cycles, dm_rdata = 0, dm_valid in the following cycle.
- Timeout with TIMEOUT = 4: no ack → mem_req high for exactly 4 cycles, then dm_valid with rdata = 0 and err_timeout = 1; err_timeout persists into the next good transaction.
- Spurious ack: mem_ack pulsed in IDLE → err_spurious = 1, no valid pulse, FSM stays in IDLE.
- Reset mid-op: rst_n low while in BUSY_DM → next cycle mem_req = 0, valid = 0, state IDLE. A later ack sets err_spurious.
